// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the 8-bit accumulator processor control path:
//   - field widths of the state register and the IR opcode field
//   - opcode codes carried in IR[7:5]
//   - control-FSM state encodings (visible on DisplayState)
//   - A-register source select codes
//   - opcode -> execute-state mapping helper
// -----------------------------------------------------------------------------
package proc_pkg;

  localparam int STATE_W = 4;
  localparam int OPC_W   = 3;

  // Opcodes as found in IR[7:5]
  localparam logic [OPC_W-1:0] OP_LOAD  = 3'b000;
  localparam logic [OPC_W-1:0] OP_STORE = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD   = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB   = 3'b011;
  localparam logic [OPC_W-1:0] OP_INPUT = 3'b100;
  localparam logic [OPC_W-1:0] OP_JZ    = 3'b101;
  localparam logic [OPC_W-1:0] OP_JPOS  = 3'b110;
  localparam logic [OPC_W-1:0] OP_HALT  = 3'b111;

  // Execute states are {1, opcode}; codes 0011..0111 are unused.
  typedef enum logic [STATE_W-1:0] {
    S_START  = 4'b0000,
    S_FETCH  = 4'b0001,
    S_DECODE = 4'b0010,
    S_LOAD   = 4'b1000,
    S_STORE  = 4'b1001,
    S_ADD    = 4'b1010,
    S_SUB    = 4'b1011,
    S_INPUT  = 4'b1100,
    S_JZ     = 4'b1101,
    S_JPOS   = 4'b1110,
    S_HALT   = 4'b1111
  } state_e;

  // A-register source select
  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  // Map an opcode to its execute state (equivalent to {1'b1, opc}).
  function automatic state_e opc_to_state(input logic [OPC_W-1:0] opc);
    state_e st;
    case (opc)
      OP_LOAD:  st = S_LOAD;
      OP_STORE: st = S_STORE;
      OP_ADD:   st = S_ADD;
      OP_SUB:   st = S_SUB;
      OP_INPUT: st = S_INPUT;
      OP_JZ:    st = S_JZ;
      OP_JPOS:  st = S_JPOS;
      OP_HALT:  st = S_HALT;
      default:  st = S_START;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/enter_edge_detect.sv
// -----------------------------------------------------------------------------
// enter_edge_detect
// Rising-edge detector for the user Enter strobe. The delayed copy is sampled
// every clock, so a level held high produces exactly one rise, and a rise that
// happens while the FSM is busy elsewhere is simply lost (not queued).
// Ports:
//   clock   in  system clock
//   reset   in  asynchronous active-low reset (clears the delayed copy)
//   i_enter in  Enter level
//   o_rise  out Enter & ~Enter_q
// -----------------------------------------------------------------------------
module enter_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic i_enter,
  output logic o_rise
);

  logic r_enter_q;

  // Delayed copy of Enter, sampled every clock
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_enter_q <= 1'b0;
    end else begin
      r_enter_q <= i_enter;
    end
  end

  assign o_rise = i_enter & ~r_enter_q;

endmodule

// File: rtl/processor_control_unit.sv
// -----------------------------------------------------------------------------
// processor_control_unit
// Moore-style control FSM of the 8-bit accumulator processor. Steps the
// datapath through START -> FETCH -> DECODE -> execute state, where the execute
// state is chosen by the opcode in IR[7:5]. Outputs decode from the registered
// state; the only input-qualified strobes are INPUT's Aload (needs an Enter
// rise) and the conditional jumps' PCload/JMPmux (need Aeq0 / Apos).
// Ports:
//   clock, reset          clock and asynchronous active-low reset
//   Enter                 user input strobe (level)
//   IR75                  opcode field of IR
//   Aeq0, Apos            accumulator status
//   IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub
//                         datapath controls
//   Halt                  high while in HALT
//   DisplayState          current state code for debug LEDs
// -----------------------------------------------------------------------------
module processor_control_unit
  import proc_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               Enter,
  input  logic [OPC_W-1:0]   IR75,
  input  logic               Aeq0,
  input  logic               Apos,
  output logic               IRload,
  output logic               JMPmux,
  output logic               PCload,
  output logic               Meminst,
  output logic               MemWr,
  output logic [1:0]         Asel,
  output logic               Aload,
  output logic               Sub,
  output logic               Halt,
  output logic [STATE_W-1:0] DisplayState
);

  state_e r_state;
  state_e w_next_state;
  logic   w_enter_rise;

  enter_edge_detect u_enter_edge_detect (
    .clock   (clock),
    .reset   (reset),
    .i_enter (Enter),
    .o_rise  (w_enter_rise)
  );

  // State register; reset drops straight to START so an in-flight
  // instruction issues no further strobes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_START;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control-output decode
  always_comb begin
    w_next_state = S_START;
    IRload       = 1'b0;
    JMPmux       = 1'b0;
    PCload       = 1'b0;
    Meminst      = 1'b0;
    MemWr        = 1'b0;
    Asel         = ASEL_ALU;
    Aload        = 1'b0;
    Sub          = 1'b0;
    Halt         = 1'b0;
    case (r_state)
      S_START: begin
        w_next_state = S_FETCH;
      end
      S_FETCH: begin
        // IR <= mem[PC], PC <= PC + 1 in the same cycle
        IRload       = 1'b1;
        PCload       = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        // Present IR[4:0] as address so operand data is ready in execute
        Meminst      = 1'b1;
        w_next_state = opc_to_state(IR75);
      end
      S_LOAD: begin
        Meminst      = 1'b1;
        Asel         = ASEL_MEM;
        Aload        = 1'b1;
        w_next_state = S_START;
      end
      S_STORE: begin
        Meminst      = 1'b1;
        MemWr        = 1'b1;
        w_next_state = S_START;
      end
      S_ADD: begin
        Asel         = ASEL_ALU;
        Aload        = 1'b1;
        w_next_state = S_START;
      end
      S_SUB: begin
        Asel         = ASEL_ALU;
        Sub          = 1'b1;
        Aload        = 1'b1;
        w_next_state = S_START;
      end
      S_INPUT: begin
        Asel = ASEL_IN;
        // Wait here until a fresh Enter rise; load in that same cycle
        if (w_enter_rise) begin
          Aload        = 1'b1;
          w_next_state = S_START;
        end else begin
          Aload        = 1'b0;
          w_next_state = S_INPUT;
        end
      end
      S_JZ: begin
        if (Aeq0) begin
          PCload = 1'b1;
          JMPmux = 1'b1;
        end else begin
          PCload = 1'b0;
          JMPmux = 1'b0;
        end
        w_next_state = S_START;
      end
      S_JPOS: begin
        if (Apos) begin
          PCload = 1'b1;
          JMPmux = 1'b1;
        end else begin
          PCload = 1'b0;
          JMPmux = 1'b0;
        end
        w_next_state = S_START;
      end
      S_HALT: begin
        Halt         = 1'b1;
        w_next_state = S_HALT;
      end
      default: begin
        // Unused codes 0011..0111 recover to START
        w_next_state = S_START;
      end
    endcase
  end

  assign DisplayState = r_state;

endmodule
